// File: rtl/adc_spi_responder.sv
// -----------------------------------------------------------------------------
// adc_spi_responder
//
// Emulates one 10-bit serial ADC channel on the far end of an SPI link. Each
// chip-select frame shifts out LEAD_ZEROS zero bits, the held sample MSB first,
// then trailing zeros up to FRAME_LEN bits. Data changes after each serial-clock
// falling edge so the reader can sample on the rising edge.
//
// Optional build macro: ADC_RESP_RAMP_EN
//   defined   : frame value comes from an internal ramp counter that advances
//               on every completed frame; sample_in/sample_valid are ignored
//               and underrun is never raised.
//   undefined : frame value comes from the hold register loaded by
//               sample_valid, with underrun reporting.
//
// Ports
//   clk           in   system clock, all logic on its rising edge
//   reset         in   synchronous active-high reset
//   SPI_clk       in   serial clock from the reader (asynchronous)
//   CS            in   active-low chip select from the reader (asynchronous)
//   sample_in     in   [DATA_W] next sample value
//   sample_valid  in   loads sample_in into the hold register
//   SPI_Data_out  out  serial data to the reader
//   busy          out  high while a frame is in progress
//   frame_done    out  one-cycle pulse when a complete frame ends
//   frame_abort   out  one-cycle pulse when CS rises before FRAME_LEN edges
//   underrun      out  one-cycle pulse when a frame starts on a stale sample
// -----------------------------------------------------------------------------
module adc_spi_responder #(
  parameter int DATA_W     = 10,
  parameter int LEAD_ZEROS = 4,
  parameter int FRAME_LEN  = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              SPI_clk,
  input  logic              CS,
  input  logic [DATA_W-1:0] sample_in,
  input  logic              sample_valid,
  output logic              SPI_Data_out,
  output logic              busy,
  output logic              frame_done,
  output logic              frame_abort,
  output logic              underrun
);

  localparam int TRAIL_ZEROS = FRAME_LEN - LEAD_ZEROS - DATA_W;
  localparam int CNT_W       = $clog2(FRAME_LEN + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FRAME_LEN);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SHIFT,
    S_TAIL
  } state_e;

  // ---------------------------------------------------------------------------
  // Synchronizers: [0] and [1] are the two metastability stages, [2] is the
  // history flop used for edge detection.
  // ---------------------------------------------------------------------------
  logic [2:0] sclk_sync_q;
  logic [2:0] cs_sync_q;

  // NOTE: the synchronizer chains carry no reset on purpose. They simply track
  // the pins, so a reset while CS is held low cannot manufacture a false CS
  // edge when the chain would otherwise be forced to an idle value.
  always_ff @(posedge clk) begin
    sclk_sync_q <= {sclk_sync_q[1:0], SPI_clk};
    cs_sync_q   <= {cs_sync_q[1:0], CS};
  end

  logic sclk_fall;
  logic cs_fall;
  logic cs_rise;

  assign sclk_fall = sclk_sync_q[2] & ~sclk_sync_q[1];
  assign cs_fall   = cs_sync_q[2]   & ~cs_sync_q[1];
  assign cs_rise   = ~cs_sync_q[2]  &  cs_sync_q[1];

  // ---------------------------------------------------------------------------
  // Frame state
  // ---------------------------------------------------------------------------
  state_e               state_q;
  logic [FRAME_LEN-1:0] shift_q;
  logic [CNT_W-1:0]     cnt_q;
  logic                 busy_q;
  logic                 frame_done_q;
  logic                 frame_abort_q;
  logic                 underrun_q;

  logic                 frame_start;
  logic                 frame_end_ok;
  logic [DATA_W-1:0]    frame_value;
  logic                 stale_sample;
  logic [FRAME_LEN-1:0] frame_word_d;

  assign frame_start = (state_q == S_IDLE) & cs_fall;

  // A CS rise counts as a completed frame once all FRAME_LEN edges were seen,
  // including the single cycle where SHIFT holds a full count before TAIL.
  assign frame_end_ok = cs_rise &
                        ((state_q == S_TAIL) |
                         ((state_q == S_SHIFT) & (cnt_q == CNT_LAST)));

  assign frame_word_d = FRAME_LEN'(frame_value) << TRAIL_ZEROS;

`ifdef ADC_RESP_RAMP_EN
  // ---------------------------------------------------------------------------
  // Ramp source: value advances only on completed frames.
  // ---------------------------------------------------------------------------
  logic [DATA_W-1:0] ramp_q;
  logic              unused_sample_inputs;

  assign unused_sample_inputs = ^{sample_in, sample_valid};

  always_ff @(posedge clk) begin
    if (reset) begin
      ramp_q <= '0;
    end else if (frame_end_ok) begin
      ramp_q <= ramp_q + DATA_W'(1);
    end
  end

  assign frame_value  = ramp_q;
  assign stale_sample = 1'b0;
`else
  // ---------------------------------------------------------------------------
  // Hold register and freshness flag. A sample arriving in the same cycle as a
  // frame start misses that frame but remains fresh for the next one.
  // ---------------------------------------------------------------------------
  logic [DATA_W-1:0] hold_q;
  logic              fresh_q;

  // NOTE: every register below is state, so it is written with non-blocking
  // assignments only; blocking writes here would make read order matter.
  always_ff @(posedge clk) begin
    if (reset) begin
      hold_q  <= '0;
      fresh_q <= 1'b0;
    end else begin
      if (sample_valid) begin
        hold_q <= sample_in;
      end
      if (frame_start) begin
        fresh_q <= sample_valid;
      end else if (sample_valid) begin
        fresh_q <= 1'b1;
      end
    end
  end

  assign frame_value  = hold_q;
  assign stale_sample = ~fresh_q;
`endif

  // ---------------------------------------------------------------------------
  // Frame FSM with registered status outputs.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= S_IDLE;
      shift_q       <= '0;
      cnt_q         <= '0;
      busy_q        <= 1'b0;
      frame_done_q  <= 1'b0;
      frame_abort_q <= 1'b0;
      underrun_q    <= 1'b0;
    end else begin
      frame_done_q  <= 1'b0;
      frame_abort_q <= 1'b0;
      underrun_q    <= 1'b0;

      unique case (state_q)
        S_IDLE: begin
          if (cs_fall) begin
            shift_q    <= frame_word_d;
            cnt_q      <= '0;
            underrun_q <= stale_sample;
            busy_q     <= 1'b1;
            state_q    <= S_SHIFT;
          end
        end

        S_SHIFT: begin
          // cs_rise has priority over a coincident sclk_fall.
          if (cs_rise) begin
            frame_done_q  <= frame_end_ok;
            frame_abort_q <= ~frame_end_ok;
            busy_q        <= 1'b0;
            state_q       <= S_IDLE;
          end else if (cnt_q == CNT_LAST) begin
            state_q <= S_TAIL;
          end else if (sclk_fall) begin
            shift_q <= {shift_q[FRAME_LEN-2:0], 1'b0};
            cnt_q   <= cnt_q + CNT_W'(1);
          end
        end

        S_TAIL: begin
          if (cs_rise) begin
            frame_done_q <= 1'b1;
            busy_q       <= 1'b0;
            state_q      <= S_IDLE;
          end
        end

        default: begin
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  // Built only from registers; the shift register is all zeros by TAIL and the
  // state term masks leftover bits after an abort.
  assign SPI_Data_out = shift_q[FRAME_LEN-1] & (state_q == S_SHIFT);
  assign busy         = busy_q;
  assign frame_done   = frame_done_q;
  assign frame_abort  = frame_abort_q;
  assign underrun     = underrun_q;

endmodule
